// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
// Shares one spimemio-style flash read port between two read requesters
// (round-robin) and one config-register writer (highest priority). Accesses
// are serialised, a config write never overlaps a read, and every read is
// bounded by an optional timeout that completes it with all-ones data and err.
module spi_flash_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // read requester 0
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  output logic              req0_ready_o,
  output logic [31:0]       req0_rdata_o,
  output logic              req0_err_o,
  // read requester 1
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              req1_ready_o,
  output logic [31:0]       req1_rdata_o,
  output logic              req1_err_o,
  // config-register writer
  input  logic              cfg_valid_i,
  input  logic [3:0]        cfg_we_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic              cfg_ready_o,
  // flash controller side
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [3:0]        mem_cfgreg_we_o,
  output logic [31:0]       mem_cfgreg_di_o
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    CFG,
    DONE
  } state_t;

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  // The winner of the latest arbitration is both the round-robin history and
  // the owner of the read currently in flight, so one bit serves both roles.
  logic last_grant_q, last_grant_d;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_cfgreg_we_d;
  logic [31:0]       mem_cfgreg_di_d;
  logic              cfg_ready_d;
  logic              req0_ready_d, req1_ready_d;
  logic              req0_err_d, req1_err_d;
  logic [31:0]       req0_rdata_d, req1_rdata_d;

  logic        pick;         // requester chosen if a read is granted this cycle
  logic        timeout_hit;  // last permitted XFER cycle without mem_ready_i
  logic [31:0] xfer_data;    // data returned to the owner on completion

  assign pick        = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == LAST_WAIT);
  // A coincident mem_ready_i beats the timeout, so real data wins.
  assign xfer_data   = mem_ready_i ? mem_rdata_i : 32'hFFFF_FFFF;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wait_cnt_d      = wait_cnt_q;
    mem_valid_d     = mem_valid_o;
    mem_addr_d      = mem_addr_o;
    mem_cfgreg_we_d = 4'h0;
    mem_cfgreg_di_d = mem_cfgreg_di_o;
    cfg_ready_d     = 1'b0;
    req0_ready_d    = 1'b0;
    req1_ready_d    = 1'b0;
    req0_err_d      = 1'b0;
    req1_err_d      = 1'b0;
    req0_rdata_d    = req0_rdata_o;
    req1_rdata_d    = req1_rdata_o;

    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          mem_cfgreg_we_d = cfg_we_i;
          mem_cfgreg_di_d = cfg_wdata_i;
          cfg_ready_d     = 1'b1;
          state_d         = CFG;
        end else if (req0_valid_i || req1_valid_i) begin
          last_grant_d = pick;
          mem_addr_d   = pick ? req1_addr_i : req0_addr_i;
          mem_valid_d  = 1'b1;
          wait_cnt_d   = '0;
          state_d      = XFER;
        end
      end

      XFER: begin
        if (mem_ready_i || timeout_hit) begin
          mem_valid_d = 1'b0;
          state_d     = DONE;
          if (last_grant_q) begin
            req1_ready_d = 1'b1;
            req1_rdata_d = xfer_data;
            req1_err_d   = ~mem_ready_i;
          end else begin
            req0_ready_d = 1'b1;
            req0_rdata_d = xfer_data;
            req0_err_d   = ~mem_ready_i;
          end
        end else if (TIMEOUT_EN) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // The one-cycle pulses issued on entry are cleared by the defaults.
      CFG:     state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any access.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      wait_cnt_q      <= '0;
      mem_valid_o     <= 1'b0;
      mem_addr_o      <= '0;
      mem_cfgreg_we_o <= 4'h0;
      mem_cfgreg_di_o <= '0;
      cfg_ready_o     <= 1'b0;
      req0_ready_o    <= 1'b0;
      req1_ready_o    <= 1'b0;
      req0_err_o      <= 1'b0;
      req1_err_o      <= 1'b0;
      req0_rdata_o    <= '0;
      req1_rdata_o    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wait_cnt_q      <= wait_cnt_d;
      mem_valid_o     <= mem_valid_d;
      mem_addr_o      <= mem_addr_d;
      mem_cfgreg_we_o <= mem_cfgreg_we_d;
      mem_cfgreg_di_o <= mem_cfgreg_di_d;
      cfg_ready_o     <= cfg_ready_d;
      req0_ready_o    <= req0_ready_d;
      req1_ready_o    <= req1_ready_d;
      req0_err_o      <= req0_err_d;
      req1_err_o      <= req1_err_d;
      req0_rdata_o    <= req0_rdata_d;
      req1_rdata_o    <= req1_rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter
// Directed bench: a transaction-level model predicts every output each cycle,
// and literal expectations pin latencies, grant order and data values.
module tb_spi_flash_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        req0_valid_i, req1_valid_i, cfg_valid_i;
  logic [23:0] req0_addr_i, req1_addr_i;
  logic        req0_ready_o, req1_ready_o, cfg_ready_o;
  logic [31:0] req0_rdata_o, req1_rdata_o;
  logic        req0_err_o, req1_err_o;
  logic [3:0]  cfg_we_i;
  logic [31:0] cfg_wdata_i;
  logic        mem_valid_o;
  logic [23:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [3:0]  mem_cfgreg_we_o;
  logic [31:0] mem_cfgreg_di_o;

  spi_flash_arbiter #(
    .ADDR_W(24),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(11)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req0_valid_i(req0_valid_i),
    .req0_addr_i(req0_addr_i),
    .req0_ready_o(req0_ready_o),
    .req0_rdata_o(req0_rdata_o),
    .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i),
    .req1_addr_i(req1_addr_i),
    .req1_ready_o(req1_ready_o),
    .req1_rdata_o(req1_rdata_o),
    .req1_err_o(req1_err_o),
    .cfg_valid_i(cfg_valid_i),
    .cfg_we_i(cfg_we_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_ready_o(cfg_ready_o),
    .mem_valid_o(mem_valid_o),
    .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_cfgreg_we_o(mem_cfgreg_we_o),
    .mem_cfgreg_di_o(mem_cfgreg_di_o)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] flash_data(input logic [23:0] a);
    return (a == 24'h000100) ? 32'hDEADBEEF : {8'h5A, a};
  endfunction

  // ---------------- flash responder ----------------
  int flash_lat = 0;  // 0 = never answers
  int late_req  = 0;  // bumped by stimulus to request one stray ready pulse
  int late_done = 0;
  int lat_cnt   = 0;
  initial begin : flash
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        lat_cnt     = 0;
      end else if (late_req != late_done) begin
        late_done++;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hA5A5A5A5;
      end else if (mem_valid_o && flash_lat != 0) begin
        lat_cnt++;
        if (lat_cnt >= flash_lat) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = flash_data(mem_addr_o);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Tracks an owner, how long it has waited, and a cool-down before the next
  // decision; outputs are what each rule says must be visible next cycle.
  bit          model_on = 1'b0;
  bit          e_valid, e_cfg_rdy;
  logic [23:0] e_addr;
  bit          e_rdy[2], e_err[2];
  logic [31:0] e_rdata[2];
  logic [3:0]  e_we;
  logic [31:0] e_di;
  int          m_last, m_who, m_waited, m_quiet;
  bit          m_busy;

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst_i) begin
        e_valid = 0; e_addr = '0; e_cfg_rdy = 0; e_we = '0; e_di = '0;
        e_rdy = '{0, 0}; e_err = '{0, 0}; e_rdata = '{32'h0, 32'h0};
        m_last = 1; m_busy = 0; m_quiet = 0; m_waited = 0; m_who = 0;
        model_on = 1'b1;
      end else if (model_on) begin
        e_rdy = '{0, 0}; e_err = '{0, 0}; e_cfg_rdy = 0; e_we = '0;
        if (m_quiet > 0) begin
          m_quiet--;
        end else if (m_busy) begin
          if (mem_ready_i || (TIMEOUT != 0 && m_waited == TIMEOUT - 1)) begin
            e_rdy[m_who]   = 1;
            e_err[m_who]   = !mem_ready_i;
            e_rdata[m_who] = mem_ready_i ? mem_rdata_i : 32'hFFFFFFFF;
            e_valid = 0; m_busy = 0; m_quiet = 1;
          end else begin
            m_waited++;
          end
        end else if (cfg_valid_i) begin
          e_we = cfg_we_i; e_di = cfg_wdata_i; e_cfg_rdy = 1; m_quiet = 1;
        end else if (req0_valid_i || req1_valid_i) begin
          if (req0_valid_i && req1_valid_i) m_who = 1 - m_last;
          else m_who = req1_valid_i ? 1 : 0;
          m_last = m_who; m_busy = 1; m_waited = 0;
          e_valid = 1; e_addr = (m_who == 1) ? req1_addr_i : req0_addr_i;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("mem_valid", 32'(mem_valid_o), 32'(e_valid));
        check("mem_addr", 32'(mem_addr_o), 32'(e_addr));
        check("req0_ready", 32'(req0_ready_o), 32'(e_rdy[0]));
        check("req0_err", 32'(req0_err_o), 32'(e_err[0]));
        check("req0_rdata", req0_rdata_o, e_rdata[0]);
        check("req1_ready", 32'(req1_ready_o), 32'(e_rdy[1]));
        check("req1_err", 32'(req1_err_o), 32'(e_err[1]));
        check("req1_rdata", req1_rdata_o, e_rdata[1]);
        check("cfg_ready", 32'(cfg_ready_o), 32'(e_cfg_rdy));
        check("cfgreg_we", 32'(mem_cfgreg_we_o), 32'(e_we));
        check("cfgreg_di", mem_cfgreg_di_o, e_di);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int          who;   // 0 = req0, 1 = req1, 2 = cfg
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic [3:0]  we;
    logic [31:0] di;
  } evt_t;

  evt_t        evq[$];
  int          gcyc[$];
  logic [23:0] gaddr[$];
  int          vcycles;

  // Runs up to max_cyc cycles (or until want completions), logging grants and
  // pulses; requesters drop valid the cycle after their pulse when drop_each.
  task automatic run(input int max_cyc, input int want, input bit drop_each, input int cfg_at);
    bit prev_v, d0, d1, dc;
    prev_v = 1'b0;
    evq.delete(); gcyc.delete(); gaddr.delete(); vcycles = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (want > 0 && evq.size() >= want) break;
      d0 = 0; d1 = 0; dc = 0;
      @(negedge clk);
      if (mem_valid_o) vcycles++;
      if (mem_valid_o && !prev_v) begin
        gcyc.push_back(cyc);
        gaddr.push_back(mem_addr_o);
      end
      prev_v = mem_valid_o;
      if (req0_ready_o) begin
        evq.push_back('{who: 0, cyc: cyc, data: req0_rdata_o, err: req0_err_o, we: 4'h0, di: 32'h0});
        d0 = drop_each;
      end
      if (req1_ready_o) begin
        evq.push_back('{who: 1, cyc: cyc, data: req1_rdata_o, err: req1_err_o, we: 4'h0, di: 32'h0});
        d1 = drop_each;
      end
      if (cfg_ready_o) begin
        evq.push_back('{who: 2, cyc: cyc, data: 32'h0, err: 1'b0, we: mem_cfgreg_we_o, di: mem_cfgreg_di_o});
        dc = 1;
      end
      @(posedge clk);
      #1;
      if (d0) req0_valid_i = 1'b0;
      if (d1) req1_valid_i = 1'b0;
      if (dc) cfg_valid_i = 1'b0;
      if (i == cfg_at) cfg_valid_i = 1'b1;
    end
    check("event_count", evq.size(), want);
    if (want > 0) begin
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; cfg_valid_i = 1'b0;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int t0;
    rst_i = 1'b1;
    req0_valid_i = 0; req0_addr_i = '0;
    req1_valid_i = 0; req1_addr_i = '0;
    cfg_valid_i = 0; cfg_we_i = '0; cfg_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_mem_valid", 32'(mem_valid_o), 32'h0);
    check("reset_req0_rdata", req0_rdata_o, 32'h0);
    check("reset_cfgreg_we", 32'(mem_cfgreg_we_o), 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // single read with 8-cycle flash latency
    flash_lat = 8;
    @(posedge clk);
    #1;
    req0_addr_i = 24'h000100; req0_valid_i = 1; t0 = cyc;
    run(100, 1, 1, -1);
    check("single_valid_latency", gcyc[0] - t0, 1);
    check("single_addr", 32'(gaddr[0]), 32'h00000100);
    check("single_valid_cycles", vcycles, 8);
    check("single_ready_latency", evq[0].cyc - t0, 9);
    check("single_rdata", evq[0].data, 32'hDEADBEEF);
    check("single_err", 32'(evq[0].err), 32'h0);

    // single read from requester 1
    flash_lat = 2;
    req1_addr_i = 24'h000200; req1_valid_i = 1;
    run(100, 1, 1, -1);
    check("req1_who", evq[0].who, 1);
    check("req1_rdata", evq[0].data, 32'h5A000200);

    // contention: both held valid, expect req0, req1, req0, req1
    flash_lat = 3;
    req0_addr_i = 24'h000010; req1_addr_i = 24'h000020;
    req0_valid_i = 1; req1_valid_i = 1;
    run(200, 4, 0, -1);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", evq[k].who, k % 2);
      check("rr_addr", 32'(gaddr[k]), (k % 2 == 0) ? 32'h10 : 32'h20);
    end

    // config beats a read raised in the same idle cycle
    flash_lat = 2;
    cfg_we_i = 4'hF; cfg_wdata_i = 32'h80000000; cfg_valid_i = 1;
    req1_addr_i = 24'h000030; req1_valid_i = 1; t0 = cyc;
    run(100, 2, 1, -1);
    check("cfgprio_first", evq[0].who, 2);
    check("cfgprio_latency", evq[0].cyc - t0, 1);
    check("cfgprio_we", 32'(evq[0].we), 32'hF);
    check("cfgprio_di", evq[0].di, 32'h80000000);
    check("cfgprio_read_start", gcyc[0] - evq[0].cyc, 2);
    check("cfgprio_second", evq[1].who, 1);

    // config raised mid-read waits for that read's completion
    flash_lat = 6;
    cfg_we_i = 4'h3; cfg_wdata_i = 32'h12345678;
    req0_addr_i = 24'h000300; req0_valid_i = 1;
    run(100, 2, 1, 2);
    check("cfgmid_first", evq[0].who, 0);
    check("cfgmid_second", evq[1].who, 2);
    check("cfgmid_gap", evq[1].cyc - evq[0].cyc, 2);
    check("cfgmid_we", 32'(evq[1].we), 32'h3);

    // timeout: flash never answers
    flash_lat = 0;
    req0_addr_i = 24'h000040; req0_valid_i = 1; t0 = cyc;
    run(100, 1, 1, -1);
    check("timeout_valid_cycles", vcycles, TIMEOUT);
    check("timeout_latency", evq[0].cyc - t0, TIMEOUT + 1);
    check("timeout_rdata", evq[0].data, 32'hFFFFFFFF);
    check("timeout_err", 32'(evq[0].err), 32'h1);

    // late mem_ready_i while idle is ignored
    late_req++;
    run(6, 0, 1, -1);
    check("late_no_valid", vcycles, 0);
    check("late_rdata_held", req0_rdata_o, 32'hFFFFFFFF);

    // ready coincident with the timeout cycle returns real data
    flash_lat = TIMEOUT;
    req1_addr_i = 24'h000050; req1_valid_i = 1;
    run(100, 1, 1, -1);
    check("coinc_valid_cycles", vcycles, TIMEOUT);
    check("coinc_rdata", evq[0].data, 32'h5A000050);
    check("coinc_err", 32'(evq[0].err), 32'h0);

    // reset in the middle of a read, then req0 wins the first tie
    flash_lat = 0;
    req0_addr_i = 24'h000060; req0_valid_i = 1;
    run(4, 0, 1, -1);
    check("pre_reset_busy", 32'(mem_valid_o), 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    flash_lat = 2;
    req1_addr_i = 24'h000070; req1_valid_i = 1;
    @(negedge clk);
    check("abort_mem_valid", 32'(mem_valid_o), 32'h0);
    check("abort_mem_addr", 32'(mem_addr_o), 32'h0);
    check("abort_req0_ready", 32'(req0_ready_o), 32'h0);
    check("abort_req0_rdata", req0_rdata_o, 32'h0);
    check("abort_cfgreg_di", mem_cfgreg_di_o, 32'h0);
    run(100, 2, 1, -1);
    check("post_reset_addr", 32'(gaddr[0]), 32'h60);
    check("post_reset_first", evq[0].who, 0);
    check("post_reset_second", evq[1].who, 1);
    check("post_reset_rdata", evq[1].data, 32'h5A000070);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
